binary_index_decoder: RTL and testbench

- Sequential counterpart to the 8-to-3 priority encoder. It takes the encoder's binary index and Done strobe, and drives a registered one-hot line OUT[index] for a fixed number of cycles.
- After each drive it enforces an idle gap, then accepts the next index.
- It sits downstream of the encoder and turns the winning request number back into a one-hot service/grant pulse.
- It also reports completion and flags an overrun when a new request arrives while busy.

---
 rtl/binary_index_decoder_pkg.sv | 18 +
 rtl/binary_index_decoder_onehot.sv | 17 +
 rtl/binary_index_decoder.sv | 105 ++++++++++
 tb/tb_binary_index_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/binary_index_decoder_pkg.sv
// Shared definitions for the binary index decoder: FSM state encoding,
// counter width and the one-hot output width derived from the index width.
package binary_index_decoder_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

    // Hold/gap counter width, wide enough for values up to 255
    localparam int CNT_W = 8;

    // One-hot width for an index of width n
    function automatic int out_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/binary_index_decoder_onehot.sv
// Combinational N-to-2**N decoder: turns a binary index into a one-hot word.
module onehot_from_index
    import binary_index_decoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]            idx,
    output logic [out_width(N)-1:0] onehot
);

    // Exactly one bit set, at position idx
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/binary_index_decoder.sv
// Sequential index decoder: accepts an encoder index on Done, drives a
// registered one-hot OUT for HOLD cycles, then idles GAP cycles before
// accepting again. Flags requests that arrive while busy (OVERRUN).
module binary_index_decoder
    import binary_index_decoder_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [N-1:0]            Y,
    input  logic                    Done,
    output logic [out_width(N)-1:0] OUT,
    output logic                    READY,
    output logic                    FINISH,
    output logic                    OVERRUN
);

    localparam int OW = out_width(N);

    // Counter reload values; a zero GAP skips the gap state entirely
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam bit               HAS_GAP   = (GAP > 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [OW-1:0]    out_r;
    logic             overrun_r;
    logic [OW-1:0]    decoded;

    // Y is decoded here but only captured into OUT on the accepting edge
    onehot_from_index #(.N(N)) u_decode (
        .idx    (Y),
        .onehot (decoded)
    );

    // FSM, hold/gap counter and registered one-hot drive
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out_r <= '0;
        end else if (EN) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Done) begin
                        out_r <= decoded;
                        cnt   <= HOLD_LOAD;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        out_r <= '0;
                        if (HAS_GAP) begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    out_r <= '0;
                end
            endcase
        end
    end

    // Sticky overrun: a request while busy is dropped and remembered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_r <= 1'b0;
        end else if (EN) begin
            overrun_r <= 1'b0;
        end else if (Done && (state != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end
    end

    assign OUT     = out_r;
    assign READY   = (state == ST_IDLE);
    assign FINISH  = (state == ST_DRIVE) && (cnt == '0);
    assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_binary_index_decoder.sv
// Directed bench for binary_index_decoder: one instance with HOLD=4/GAP=1,
// one with HOLD=1/GAP=0, expected values written out by hand.
module tb_binary_index_decoder;

    logic       CLK;
    logic       a_rst_n, a_en, a_done;
    logic [2:0] a_y;
    logic [7:0] a_out;
    logic       a_ready, a_finish, a_overrun;

    logic       b_rst_n, b_en, b_done;
    logic [2:0] b_y;
    logic [7:0] b_out;
    logic       b_ready, b_finish, b_overrun;

    int n_vec  = 0;
    int n_miss = 0;

    binary_index_decoder #(.N(3), .HOLD(4), .GAP(1)) dut_a (
        .CLK     (CLK),
        .RST_N   (a_rst_n),
        .EN      (a_en),
        .Y       (a_y),
        .Done    (a_done),
        .OUT     (a_out),
        .READY   (a_ready),
        .FINISH  (a_finish),
        .OVERRUN (a_overrun)
    );

    binary_index_decoder #(.N(3), .HOLD(1), .GAP(0)) dut_b (
        .CLK     (CLK),
        .RST_N   (b_rst_n),
        .EN      (b_en),
        .Y       (b_y),
        .Done    (b_done),
        .OUT     (b_out),
        .READY   (b_ready),
        .FINISH  (b_finish),
        .OVERRUN (b_overrun)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_en = 1'b0; a_done = 1'b0; a_y = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_done = 1'b0; b_y = '0;
        #2;
        check_vec("rst_out",     32'(a_out),     32'h00);
        check_vec("rst_ready",   32'(a_ready),   32'h1);
        check_vec("rst_finish",  32'(a_finish),  32'h0);
        check_vec("rst_overrun", 32'(a_overrun), 32'h0);
        step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();

        // single request Y=5: four DRIVE cycles, one GAP cycle
        a_done = 1'b1; a_y = 3'b101;
        step();
        a_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_vec("t1_out",    32'(a_out),    32'h20);
            check_vec("t1_finish", 32'(a_finish), (i == 3) ? 32'h1 : 32'h0);
            check_vec("t1_ready",  32'(a_ready),  32'h0);
            step();
        end
        check_vec("t1_gap_out",   32'(a_out),    32'h00);
        check_vec("t1_gap_ready", 32'(a_ready),  32'h0);
        check_vec("t1_gap_fin",   32'(a_finish), 32'h0);
        step();
        check_vec("t1_idle_ready", 32'(a_ready), 32'h1);

        // Done held high, Y stepping: only Y=0 accepted, then Y=6 on return
        a_done = 1'b1; a_y = 3'd0;
        step();
        for (int k = 0; k < 6; k++) begin
            check_vec("t2_out",     32'(a_out),     (k <= 3) ? 32'h01 : 32'h00);
            check_vec("t2_overrun", 32'(a_overrun), (k >= 1) ? 32'h1 : 32'h0);
            check_vec("t2_ready",   32'(a_ready),   (k == 5) ? 32'h1 : 32'h0);
            a_y = 3'(k + 1);
            step();
        end
        check_vec("t2_next_out", 32'(a_out), 32'h40);

        // EN=1 clears everything, then abort a Y=7 drive on its 2nd cycle
        a_done = 1'b0; a_en = 1'b1;
        step();
        check_vec("t3_clr_overrun", 32'(a_overrun), 32'h0);
        check_vec("t3_clr_ready",   32'(a_ready),   32'h1);
        check_vec("t3_clr_out",     32'(a_out),     32'h00);
        a_en = 1'b0; a_done = 1'b1; a_y = 3'b111;
        step();
        check_vec("t3_drive_out", 32'(a_out), 32'h80);
        step();
        check_vec("t3_overrun", 32'(a_overrun), 32'h1);
        check_vec("t3_out2",    32'(a_out),     32'h80);
        check_vec("t3_fin2",    32'(a_finish),  32'h0);
        a_en = 1'b1;
        step();
        check_vec("t3_abort_out",     32'(a_out),     32'h00);
        check_vec("t3_abort_ready",   32'(a_ready),   32'h1);
        check_vec("t3_abort_overrun", 32'(a_overrun), 32'h0);
        check_vec("t3_abort_finish",  32'(a_finish),  32'h0);
        step();
        check_vec("t3_ign_ready", 32'(a_ready), 32'h1);
        check_vec("t3_ign_out",   32'(a_out),   32'h00);
        a_en = 1'b0; a_done = 1'b0;
        step();

        // HOLD=1, GAP=0, Done held high with Y=3: OUT every other cycle
        b_done = 1'b1; b_y = 3'b011;
        step();
        for (int k = 0; k < 6; k++) begin
            check_vec("t4_out",     32'(b_out),     (k % 2 == 0) ? 32'h08 : 32'h00);
            check_vec("t4_finish",  32'(b_finish),  (k % 2 == 0) ? 32'h1 : 32'h0);
            check_vec("t4_ready",   32'(b_ready),   (k % 2 == 1) ? 32'h1 : 32'h0);
            check_vec("t4_overrun", 32'(b_overrun), (k >= 1) ? 32'h1 : 32'h0);
            step();
        end
        b_done = 1'b0;

        // asynchronous reset mid-DRIVE, between clock edges
        a_done = 1'b1; a_y = 3'd2;
        step();
        step();
        check_vec("t5_pre_overrun", 32'(a_overrun), 32'h1);
        check_vec("t5_pre_out",     32'(a_out),     32'h04);
        a_done = 1'b0;
        #2;
        a_rst_n = 1'b0;
        #1;
        check_vec("t5_rst_out",     32'(a_out),     32'h00);
        check_vec("t5_rst_ready",   32'(a_ready),   32'h1);
        check_vec("t5_rst_finish",  32'(a_finish),  32'h0);
        check_vec("t5_rst_overrun", 32'(a_overrun), 32'h0);
        step();
        a_rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
